sram_controller_pmu_handshake: RTL
==================================

# sram_controller_pmu_handshake

Controller-domain responder for the PMU power-request interface. It consumes the synchronized `pwr_save_req_sync` / `pwr_restore_req_sync` levels and sequences the SRAM into and out of retention: drain, isolate, retain, and the reverse. It returns four-phase acknowledge levels to the PMU domain, which synchronizes them on its side. It sits between the PMU synchronizer outputs and the SRAM power/isolation controls.

## Interface
Parameters:
- `ISO_SETTLE`, default 4: cycles spent in ISO and UNISO. Minimum 1.
- `RET_SETTLE`, default 8: cycles spent in RET before save ack. Minimum 1.
- `WAKE_CYCLES`, default 16: cycles spent in WAKE after retention release. Minimum 1.
- `DRAIN_TIMEOUT`, default 256: maximum DRAIN cycles. Used only with `SRAM_PMU_DRAIN_TIMEOUT_EN`.

Ports:
- `clk_ctrl` in 1: controller clock. This is the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `pwr_save_req_sync` in 1: synchronized save request level.
- `pwr_restore_req_sync` in 1: synchronized restore request level.
- `ctrl_idle` in 1: high when the controller has no outstanding SRAM transaction.
- `accept_block` out 1: high blocks new transaction acceptance upstream.
- `sram_iso` out 1: SRAM output isolation enable.
- `sram_ret` out 1: SRAM retention enable.
- `pwr_save_ack` out 1: save acknowledge level to the PMU.
- `pwr_restore_ack` out 1: restore acknowledge level to the PMU.
- `drain_err` out 1: sticky drain-timeout flag. Tied 0 without the macro.

## Operation
- All outputs are Moore-decoded from the registered state. There is no combinational input-to-output path.
- States and outputs (block/iso/ret/save_ack/restore_ack):
  - ACTIVE 0/0/0/0/0
  - DRAIN 1/0/0/0/0
  - ISO 1/1/0/0/0
  - RET 1/1/1/0/0
  - SAVE_ACK 1/1/1/1/0
  - SLEEP 1/1/1/0/0
  - WAKE 1/1/0/0/0
  - UNISO 1/0/0/0/0
  - RST_ACK 0/0/0/0/1
- Transitions:
  - ACTIVE: save_req → DRAIN (save has priority); otherwise restore_req → RST_ACK (trivial ack, already powered).
  - DRAIN → ISO at the first edge with `ctrl_idle`=1.
  - ISO → RET after `ISO_SETTLE` cycles; RET → SAVE_ACK after `RET_SETTLE` cycles.
  - SAVE_ACK → SLEEP when save_req is low.
  - SLEEP: restore_req → WAKE; otherwise save_req → SAVE_ACK (trivial ack, already asleep).
  - WAKE → UNISO after `WAKE_CYCLES` cycles; UNISO → RST_ACK after `ISO_SETTLE` cycles.
  - RST_ACK → ACTIVE when restore_req is low.
- Request levels are ignored during ISO, RET, WAKE and UNISO; a sequence once started always completes.
- In SAVE_ACK, restore_req is ignored until save_req drops. In RST_ACK, save_req is ignored until restore_req drops.
- A single down-counter is shared by the timed states. It is sized by clog2 of the maximum parameter (including `DRAIN_TIMEOUT` when the macro is enabled) and reloaded on every state entry.

## Timing
- Reset: state ACTIVE, counter 0, and every output 0 (including `drain_err`) on the edge after `reset_n` is sampled low.
- Reset mid-sequence aborts immediately to ACTIVE. SRAM contents are not guaranteed after this.
- Save latency: with save_req sampled high at edge E and `ctrl_idle`=1:
  - DRAIN entered at E+1, ISO at E+2, RET at E+2+`ISO_SETTLE`.
  - `pwr_save_ack` rises at E+2+`ISO_SETTLE`+`RET_SETTLE` (E+14 with defaults).
- Restore latency: with restore_req sampled high in SLEEP at E, `pwr_restore_ack` rises at E+1+`WAKE_CYCLES`+`ISO_SETTLE` (E+21 with defaults).
- Ack deassertion: the ack falls 1 cycle after the edge where the request is sampled low.
- Trivial acks (restore in ACTIVE, save in SLEEP) rise at E+1.
- `accept_block` rises before `sram_iso` and falls only after `sram_iso` is low.

## Configuration
- `SRAM_PMU_DRAIN_TIMEOUT_EN` defined:
  - DRAIN exits to ISO after `DRAIN_TIMEOUT` cycles even if `ctrl_idle`=0.
  - Any such forced exit sets `drain_err`=1, which holds until reset.
- Not defined: DRAIN waits indefinitely for `ctrl_idle`, and `drain_err` is constant 0.

## Test plan
- Basic save: defaults, `ctrl_idle`=1, save_req high at edge E.
  - `accept_block` high at E+1, `sram_iso` high at E+2, `sram_ret` high at E+6, `pwr_save_ack` high at E+14.
  - Drop save_req: ack falls one cycle later, state SLEEP.
- Blocked drain: `ctrl_idle`=0 for 20 cycles after the save request.
  - `sram_iso` stays 0 throughout and rises 1 cycle after `ctrl_idle` goes high.
  - With the macro and `DRAIN_TIMEOUT`=8 (`ctrl_idle` held 0): ISO is entered at E+9 and `drain_err`=1 is sticky.
- Restore from SLEEP at edge E:
  - `sram_ret` low at E+1, `sram_iso` low at E+17, `pwr_restore_ack`=1 and `accept_block`=0 at E+21.
  - After restore_req drops: state ACTIVE.
- Trivial acks and simultaneous requests:
  - Restore in ACTIVE → ack at E+1.
  - Save in SLEEP → ack at E+1.
  - Both requests high in ACTIVE → save sequence runs and the restore ack stays 0 until the save handshake completes.
- Reset mid-sequence: assert `reset_n`=0 during RET → all outputs 0 the next cycle, and a fresh save sequence then completes normally.

Source files
------------

// File: rtl/sram_controller_pmu_handshake.sv
// sram_controller_pmu_handshake
// Controller-domain responder for the PMU power-request handshake. Sequences
// the SRAM through drain -> isolate -> retain on a save request and back out on
// a restore request, returning four-phase acknowledge levels to the PMU.
// Optional feature macro: SRAM_PMU_DRAIN_TIMEOUT_EN (bounded DRAIN, sticky drain_err).
module sram_controller_pmu_handshake #(
    parameter int ISO_SETTLE    = 4,
    parameter int RET_SETTLE    = 8,
    parameter int WAKE_CYCLES   = 16,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic clk_ctrl,
    input  logic reset_n,
    input  logic pwr_save_req_sync,
    input  logic pwr_restore_req_sync,
    input  logic ctrl_idle,
    output logic accept_block,
    output logic sram_iso,
    output logic sram_ret,
    output logic pwr_save_ack,
    output logic pwr_restore_ack,
    output logic drain_err
);

    localparam int BASE_MAX_A = (ISO_SETTLE > RET_SETTLE) ? ISO_SETTLE : RET_SETTLE;
    localparam int BASE_MAX   = (BASE_MAX_A > WAKE_CYCLES) ? BASE_MAX_A : WAKE_CYCLES;
`ifdef SRAM_PMU_DRAIN_TIMEOUT_EN
    localparam int CNT_MAX    = (DRAIN_TIMEOUT > BASE_MAX) ? DRAIN_TIMEOUT : BASE_MAX;
`else
    localparam int CNT_MAX    = BASE_MAX;
`endif
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    // Every settle count must be at least one cycle.
    if (ISO_SETTLE < 1 || RET_SETTLE < 1 || WAKE_CYCLES < 1 || DRAIN_TIMEOUT < 1) begin : g_param_check
        $error("sram_controller_pmu_handshake: settle/timeout parameters must be >= 1");
    end

    typedef enum logic [3:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_ISO,
        ST_RET,
        ST_SAVE_ACK,
        ST_SLEEP,
        ST_WAKE,
        ST_UNISO,
        ST_RST_ACK
    } state_t;

    typedef struct packed {
        logic block;
        logic iso;
        logic ret;
        logic save_ack;
        logic restore_ack;
    } ctrl_out_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_out_t        out_q;
`ifdef SRAM_PMU_DRAIN_TIMEOUT_EN
    logic             drain_err_q, drain_err_d;
`endif

    // Moore output table, one row per state.
    function automatic ctrl_out_t decode(state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            ST_DRAIN:    o = '{block: 1'b1, iso: 1'b0, ret: 1'b0, save_ack: 1'b0, restore_ack: 1'b0};
            ST_ISO:      o = '{block: 1'b1, iso: 1'b1, ret: 1'b0, save_ack: 1'b0, restore_ack: 1'b0};
            ST_RET:      o = '{block: 1'b1, iso: 1'b1, ret: 1'b1, save_ack: 1'b0, restore_ack: 1'b0};
            ST_SAVE_ACK: o = '{block: 1'b1, iso: 1'b1, ret: 1'b1, save_ack: 1'b1, restore_ack: 1'b0};
            ST_SLEEP:    o = '{block: 1'b1, iso: 1'b1, ret: 1'b1, save_ack: 1'b0, restore_ack: 1'b0};
            ST_WAKE:     o = '{block: 1'b1, iso: 1'b1, ret: 1'b0, save_ack: 1'b0, restore_ack: 1'b0};
            ST_UNISO:    o = '{block: 1'b1, iso: 1'b0, ret: 1'b0, save_ack: 1'b0, restore_ack: 1'b0};
            ST_RST_ACK:  o = '{block: 1'b0, iso: 1'b0, ret: 1'b0, save_ack: 1'b0, restore_ack: 1'b1};
            default:     o = '0;
        endcase
        return o;
    endfunction

    // Counter value loaded on entry to a state; counting down to zero gives
    // exactly N cycles of residency.
    function automatic logic [CNT_W-1:0] load_value(state_t s);
        logic [CNT_W-1:0] v;
        v = '0;
        case (s)
            ST_ISO, ST_UNISO: v = CNT_W'(ISO_SETTLE - 1);
            ST_RET:           v = CNT_W'(RET_SETTLE - 1);
            ST_WAKE:          v = CNT_W'(WAKE_CYCLES - 1);
`ifdef SRAM_PMU_DRAIN_TIMEOUT_EN
            ST_DRAIN:         v = CNT_W'(DRAIN_TIMEOUT - 1);
`endif
            default:          v = '0;
        endcase
        return v;
    endfunction

    // Next-state, shared counter and drain-error logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef SRAM_PMU_DRAIN_TIMEOUT_EN
        drain_err_d = drain_err_q;
`endif
        case (state_q)
            ST_ACTIVE: begin
                if (pwr_save_req_sync)         state_d = ST_DRAIN;
                else if (pwr_restore_req_sync) state_d = ST_RST_ACK;
            end
            ST_DRAIN: begin
                if (ctrl_idle) begin
                    state_d = ST_ISO;
                end
`ifdef SRAM_PMU_DRAIN_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d     = ST_ISO;
                    drain_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            ST_ISO: begin
                if (cnt_q == '0) state_d = ST_RET;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RET: begin
                if (cnt_q == '0) state_d = ST_SAVE_ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_SAVE_ACK: begin
                if (!pwr_save_req_sync) state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (pwr_restore_req_sync)   state_d = ST_WAKE;
                else if (pwr_save_req_sync) state_d = ST_SAVE_ACK;
            end
            ST_WAKE: begin
                if (cnt_q == '0) state_d = ST_UNISO;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_UNISO: begin
                if (cnt_q == '0) state_d = ST_RST_ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RST_ACK: begin
                if (!pwr_restore_req_sync) state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase

        if (state_d != state_q) cnt_d = load_value(state_d);
    end

    // State, counter and registered Moore outputs with synchronous reset.
    always_ff @(posedge clk_ctrl) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            out_q   <= '0;
`ifdef SRAM_PMU_DRAIN_TIMEOUT_EN
            drain_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= decode(state_d);
`ifdef SRAM_PMU_DRAIN_TIMEOUT_EN
            drain_err_q <= drain_err_d;
`endif
        end
    end

    assign accept_block    = out_q.block;
    assign sram_iso        = out_q.iso;
    assign sram_ret        = out_q.ret;
    assign pwr_save_ack    = out_q.save_ack;
    assign pwr_restore_ack = out_q.restore_ack;
`ifdef SRAM_PMU_DRAIN_TIMEOUT_EN
    assign drain_err       = drain_err_q;
`else
    assign drain_err       = 1'b0;
`endif

endmodule
